// File: rtl/state_deserializer_if.sv
// Byte channel carrying a CSF frame into the deserializer.
// The source drives valid/data/last; the deserializer answers with ready.
interface state_deserializer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/state_deserializer.sv
// CSF byte-stream receiver: rebuilds module/variable records and trailer
// fields from a little-endian frame, one byte per accepted handshake.
module state_deserializer #(
  parameter int MAX_MODULES = 16,
  parameter int MAX_VARS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  state_deserializer_if.slave   in_if,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [15:0]           byte_count,
  output logic [31:0]           num_modules,
  output logic                  mod_we,
  output logic [7:0]            mod_idx,
  output logic [31:0]           mod_id,
  output logic [31:0]           mod_var_count,
  output logic                  var_we,
  output logic [7:0]            var_mod_idx,
  output logic [7:0]            var_idx,
  output logic [31:0]           var_data,
  output logic [31:0]           mu,
  output logic [31:0]           pc,
  output logic [31:0]           halted,
  output logic [31:0]           result,
  output logic [31:0]           program_hash
);

  typedef enum logic [3:0] {
    S_IDLE, S_NUM_MOD, S_MOD_ID, S_VAR_CNT, S_VAR, S_MU_LEN, S_MU_BYTES,
    S_PC, S_HALTED, S_RESULT, S_HASH, S_DONE, S_DRAIN, S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [2:0]  mu_len_q, mu_len_d;
  logic [8:0]  cur_mod_q, cur_mod_d;
  logic [8:0]  cur_var_q, cur_var_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [31:0] num_modules_q, num_modules_d;
  logic        mod_we_q, mod_we_d;
  logic [7:0]  mod_idx_q, mod_idx_d;
  logic [31:0] mod_id_q, mod_id_d;
  logic [31:0] mod_var_count_q, mod_var_count_d;
  logic        var_we_q, var_we_d;
  logic [7:0]  var_mod_idx_q, var_mod_idx_d;
  logic [7:0]  var_idx_q, var_idx_d;
  logic [31:0] var_data_q, var_data_d;
  logic [31:0] mu_q, mu_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] halted_q, halted_d;
  logic [31:0] result_q, result_d;
  logic [31:0] program_hash_q, program_hash_d;

  logic        parsing, ready, accept, field_done, last_mod;
  logic [31:0] field_val;
  logic [8:0]  mod_next;
  logic [2:0]  cerr;

  assign parsing   = (state_q >= S_NUM_MOD) && (state_q <= S_HASH);
  assign ready     = parsing || (state_q == S_DRAIN);
  assign accept    = in_if.in_valid && ready;
  // Accumulator is cleared at field start, so OR-ing in the new byte is exact.
  assign field_val = acc_q | (32'(in_if.in_data) << {bidx_q, 3'b000});
  assign mod_next  = cur_mod_q + 9'd1;
  assign last_mod  = (mod_next == num_modules_q[8:0]);

  always_comb begin
    field_done = 1'b0;
    case (state_q)
      S_MU_LEN:   field_done = 1'b1;
      S_MU_BYTES: field_done = ({1'b0, bidx_q} == (mu_len_q - 3'd1));
      default:    field_done = (bidx_q == 2'd3);
    endcase
  end

  always_comb begin
    cerr = 3'd0;
    if (field_done) begin
      case (state_q)
        S_NUM_MOD: if (field_val > 32'(MAX_MODULES)) cerr = 3'd1;
        S_VAR_CNT: if (field_val > 32'(MAX_VARS)) cerr = 3'd2;
        S_MU_LEN:  if ((in_if.in_data == 8'd0) || (in_if.in_data > 8'd4)) cerr = 3'd3;
        default:   cerr = 3'd0;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    bidx_d          = bidx_q;
    mu_len_d        = mu_len_q;
    cur_mod_d       = cur_mod_q;
    cur_var_d       = cur_var_q;
    done_d          = done_q;
    error_d         = error_q;
    err_code_d      = err_code_q;
    byte_count_d    = byte_count_q;
    num_modules_d   = num_modules_q;
    mod_we_d        = 1'b0;
    mod_idx_d       = mod_idx_q;
    mod_id_d        = mod_id_q;
    mod_var_count_d = mod_var_count_q;
    var_we_d        = 1'b0;
    var_mod_idx_d   = var_mod_idx_q;
    var_idx_d       = var_idx_q;
    var_data_d      = var_data_q;
    mu_d            = mu_q;
    pc_d            = pc_q;
    halted_d        = halted_q;
    result_d        = result_q;
    program_hash_d  = program_hash_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d       = 1'b0;
          error_d      = 1'b0;
          err_code_d   = 3'd0;
          byte_count_d = 16'd0;
          mod_idx_d    = 8'd0;
          var_idx_d    = 8'd0;
          cur_mod_d    = 9'd0;
          cur_var_d    = 9'd0;
          acc_d        = 32'd0;
          bidx_d       = 2'd0;
          state_d      = S_NUM_MOD;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
          if (in_if.in_last) state_d = S_ERROR;
        end
      end
      default: begin
        if (accept) begin
          if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
          if (field_done) begin
            acc_d  = 32'd0;
            bidx_d = 2'd0;
          end else begin
            acc_d  = field_val;
            bidx_d = bidx_q + 2'd1;
          end
          if (state_q == S_NUM_MOD && field_done) num_modules_d = field_val;

          // Content errors outrank truncation on the same byte.
          if (cerr != 3'd0) begin
            error_d    = 1'b1;
            err_code_d = cerr;
            state_d    = in_if.in_last ? S_ERROR : S_DRAIN;
          end else if (in_if.in_last && !(state_q == S_HASH && field_done)) begin
            error_d    = 1'b1;
            err_code_d = 3'd4;
            state_d    = S_ERROR;
          end else if (field_done) begin
            case (state_q)
              S_NUM_MOD: state_d = (field_val == 32'd0) ? S_MU_LEN : S_MOD_ID;
              S_MOD_ID: begin
                mod_id_d = field_val;
                state_d  = S_VAR_CNT;
              end
              S_VAR_CNT: begin
                mod_we_d        = 1'b1;
                mod_idx_d       = cur_mod_q[7:0];
                mod_var_count_d = field_val;
                cur_var_d       = 9'd0;
                if (field_val == 32'd0) begin
                  cur_mod_d = mod_next;
                  state_d   = last_mod ? S_MU_LEN : S_MOD_ID;
                end else begin
                  state_d = S_VAR;
                end
              end
              S_VAR: begin
                var_we_d      = 1'b1;
                var_data_d    = field_val;
                var_idx_d     = cur_var_q[7:0];
                var_mod_idx_d = cur_mod_q[7:0];
                if ((cur_var_q + 9'd1) == mod_var_count_q[8:0]) begin
                  cur_var_d = 9'd0;
                  cur_mod_d = mod_next;
                  state_d   = last_mod ? S_MU_LEN : S_MOD_ID;
                end else begin
                  cur_var_d = cur_var_q + 9'd1;
                end
              end
              S_MU_LEN: begin
                mu_len_d = in_if.in_data[2:0];
                state_d  = S_MU_BYTES;
              end
              S_MU_BYTES: begin
                mu_d    = field_val;
                state_d = S_PC;
              end
              S_PC: begin
                pc_d    = field_val;
                state_d = S_HALTED;
              end
              S_HALTED: begin
                halted_d = field_val;
                state_d  = S_RESULT;
              end
              S_RESULT: begin
                result_d = field_val;
                state_d  = S_HASH;
              end
              S_HASH: begin
                program_hash_d = field_val;
                if (in_if.in_last) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
                end else begin
                  error_d    = 1'b1;
                  err_code_d = 3'd5;
                  state_d    = S_DRAIN;
                end
              end
              default: state_d = state_q;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      acc_q           <= '0;
      bidx_q          <= '0;
      mu_len_q        <= '0;
      cur_mod_q       <= '0;
      cur_var_q       <= '0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      err_code_q      <= '0;
      byte_count_q    <= '0;
      num_modules_q   <= '0;
      mod_we_q        <= 1'b0;
      mod_idx_q       <= '0;
      mod_id_q        <= '0;
      mod_var_count_q <= '0;
      var_we_q        <= 1'b0;
      var_mod_idx_q   <= '0;
      var_idx_q       <= '0;
      var_data_q      <= '0;
      mu_q            <= '0;
      pc_q            <= '0;
      halted_q        <= '0;
      result_q        <= '0;
      program_hash_q  <= '0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      bidx_q          <= bidx_d;
      mu_len_q        <= mu_len_d;
      cur_mod_q       <= cur_mod_d;
      cur_var_q       <= cur_var_d;
      done_q          <= done_d;
      error_q         <= error_d;
      err_code_q      <= err_code_d;
      byte_count_q    <= byte_count_d;
      num_modules_q   <= num_modules_d;
      mod_we_q        <= mod_we_d;
      mod_idx_q       <= mod_idx_d;
      mod_id_q        <= mod_id_d;
      mod_var_count_q <= mod_var_count_d;
      var_we_q        <= var_we_d;
      var_mod_idx_q   <= var_mod_idx_d;
      var_idx_q       <= var_idx_d;
      var_data_q      <= var_data_d;
      mu_q            <= mu_d;
      pc_q            <= pc_d;
      halted_q        <= halted_d;
      result_q        <= result_d;
      program_hash_q  <= program_hash_d;
    end
  end

  assign in_if.in_ready = ready;
  assign busy           = ready;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign byte_count     = byte_count_q;
  assign num_modules    = num_modules_q;
  assign mod_we         = mod_we_q;
  assign mod_idx        = mod_idx_q;
  assign mod_id         = mod_id_q;
  assign mod_var_count  = mod_var_count_q;
  assign var_we         = var_we_q;
  assign var_mod_idx    = var_mod_idx_q;
  assign var_idx        = var_idx_q;
  assign var_data       = var_data_q;
  assign mu             = mu_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign result         = result_q;
  assign program_hash   = program_hash_q;

endmodule

// File: doc/state_deserializer.md
Name: state_deserializer

Overview:
Byte-stream receiver for the Canonical Serialization Format (CSF). It is the inverse of the state serializer: it parses a little-endian CSF byte stream, one byte per handshake, back into Thiele Machine state. Module and variable records are emitted through write-strobe ports. Scalar fields are held on output registers. It sits between the host or loader byte channel and the state register file, and is used for state restore and round-trip checks.

Parameters:
MAX_MODULES, 16, largest legal num_modules (≤256)
MAX_VARS, 16, largest legal per-module var_count (≤256)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  arm parser for one frame; ignored unless in IDLE, DONE or ERROR
in_valid  in  1  byte offered
in_data  in  8  CSF byte
in_last  in  1  offered byte is the final byte of the frame
in_ready  out  1  byte accepted when in_valid & in_ready
busy  out  1  parsing or draining
done  out  1  frame parsed cleanly; held until next accepted start
error  out  1  frame rejected; held until next accepted start
err_code  out  3  1=num_modules>MAX_MODULES, 2=var_count>MAX_VARS, 3=bad mu length, 4=truncated (in_last early), 5=trailing (no in_last on final byte)
byte_count  out  16  bytes accepted this frame, saturating at 0xFFFF
num_modules  out  32  parsed count
mod_we  out  1  one-cycle strobe: module header complete
mod_idx  out  8  module index for mod_we
mod_id  out  32  module id
mod_var_count  out  32  module var count
var_we  out  1  one-cycle strobe: variable complete
var_mod_idx  out  8  owning module index
var_idx  out  8  variable index within module
var_data  out  32  variable value
mu  out  32  decoded mu, zero-extended
pc, halted, result, program_hash  out  32 each  parsed trailer fields

Behaviour:
- Reset: all outputs 0, state IDLE, in_ready=0.
- Frame layout:
  - num_modules u32.
  - Per module: id u32, var_count u32, then var_count × u32.
  - mu: length byte L (1..4), then L little-endian bytes.
  - pc, halted, result, program_hash: u32 each.
- All u32 fields are little-endian. A shared 32-bit accumulator and a 2-bit byte index are used; byte k loads bits [8k+7:8k]. The accumulator is cleared at the start of each field.
- States: IDLE, NUM_MOD, MOD_ID, VAR_CNT, VAR, MU_LEN, MU_BYTES, PC, HALTED, RESULT, HASH, DONE, DRAIN, ERROR.
- start accepted in IDLE, DONE or ERROR:
  - clears done, error, err_code, byte_count, mod_idx, var_idx;
  - goes to NUM_MOD next cycle.
- in_ready=1 in NUM_MOD..HASH and DRAIN; 0 in IDLE, DONE and ERROR. busy is high under exactly the same condition.
- Transitions fire on the cycle the 4th field byte is accepted (1st byte for MU_LEN; L-th byte for MU_BYTES):
  - NUM_MOD: value > MAX_MODULES → error 1. Value 0 → MU_LEN. Otherwise → MOD_ID.
  - VAR_CNT:
    - value > MAX_VARS → error 2;
    - else mod_we pulses next cycle with mod_idx/mod_id/mod_var_count;
    - then → VAR, or, if the count is 0, → next MOD_ID or MU_LEN.
  - VAR: var_we pulses next cycle, var_idx increments. After the last var: mod_idx++, var_idx=0 → MOD_ID or MU_LEN.
  - MU_LEN: L=0 or L>4 → error 3. MU_BYTES assembles mu LSB-first.
  - PC → HALTED → RESULT → HASH: each output register updates when its field completes.
  - HASH final byte: with in_last → DONE, done=1. Without in_last → error 5.
- in_last on any accepted byte before the final HASH byte → error 4, go directly to ERROR (no drain).
- Error detected on a byte without in_last → DRAIN: accept and discard bytes until in_last, then ERROR. error/err_code are set at detection, not at end of drain.
- Errors 1/2/3 detected on a byte carrying in_last → ERROR directly, with code 1/2/3 (the content error takes priority over code 4).
- Write strobes are never issued after an error is detected. Registers already written are left as-is.
- in_valid low stalls parsing with no state change; no timeout.
- start while busy is ignored.
- Reset mid-frame aborts immediately to IDLE with all outputs cleared.

Test Plan:
- Golden frame: start, then 46 bytes with in_last on the last byte. Bytes: 02000000 00000000 00000000 01000000 02000000 05000000 0A000000 012A, then 16×00.
  → mod_we ×2 (idx0: id0/cnt0; idx1: id1/cnt2); var_we ×2 (1,0,5) and (1,1,10); mu=42; done=1; byte_count=46; error=0.
- Same golden frame with in_valid toggled randomly → identical outputs and strobe sequence.
- num_modules=0 with mu bytes 04 78 56 34 12, pc=7, then trailer → mu=0x12345678, pc=7, no mod_we, done, byte_count=25.
- num_modules=17 bytes, then 5 junk bytes, the last with in_last → error=1, err_code=1 at the 4th byte; in_ready stays 1 until in_last is accepted, then 0.
- Golden frame with in_last on byte 30 → err_code=4. Golden frame without in_last on byte 46 → err_code=5, DRAIN continues until in_last.
- Mid-frame rst at byte 20 → all outputs 0. A subsequent start plus the golden frame parses cleanly.
